// File: rtl/exec_unit_mc.sv
// exec_unit_mc: multicycle execute stage; ALU/shift/BEQ in 1 clk, MUL iterative.
// Define EXEC_DIV_EN to add restoring DIV/REM; otherwise ops 10/11 are illegal.
module exec_unit_mc #(
  parameter int W    = 32,
  parameter int RW   = 5,
  parameter int ITER = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    op,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          comp_sig,
  input  logic [RW-1:0] rd_in,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [RW-1:0] rd_out,
  output logic          wr_en,
  output logic          br_taken,
  output logic          err
);

  localparam int CW = $clog2(ITER + 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_BEQ = 4'd9;
`ifdef EXEC_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd10;
  localparam logic [3:0] OP_REM = 4'd11;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;
  logic [3:0]    mop_q, mop_d;
  logic [RW-1:0] mrd_q, mrd_d;

  logic [W-1:0]  result_d;
  logic [RW-1:0] rd_out_d;
  logic          done_d, wr_en_d, err_d, br_d;

  logic [W-1:0]  sc_res;
  logic          sc_ill;
  logic          is_multi;
  logic [W-1:0]  it_acc, it_opa, it_opb, it_res;

  function automatic logic rd_ok(input logic [RW-1:0] r);
    return (r <= RW'(10)) || (r >= RW'(25));
  endfunction

  assign busy = (state_q != S_IDLE);

`ifdef EXEC_DIV_EN
  assign is_multi = (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);

  logic [W:0] div_sh, div_diff;
  assign div_sh   = {acc_q, opa_q[W-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
`else
  assign is_multi = (op == OP_MUL);
`endif

  // single-cycle ALU; anything not decoded here is illegal on this path
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    unique case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLL:  sc_res = a << b[4:0];
      OP_SRL:  sc_res = a >> b[4:0];
      OP_BEQ:  sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  // one bit of shift-add multiply or restoring divide
  always_comb begin
    it_acc = acc_q;
    it_opa = opa_q;
    it_opb = opb_q;
    it_res = '0;
    if (mop_q == OP_MUL) begin
      if (opb_q[0]) it_acc = acc_q + opa_q;
      it_opa = opa_q << 1;
      it_opb = opb_q >> 1;
      it_res = it_acc;
    end
`ifdef EXEC_DIV_EN
    else begin
      if (!div_diff[W]) begin
        it_acc = div_diff[W-1:0];
        it_opa = {opa_q[W-2:0], 1'b1};
      end else begin
        it_acc = div_sh[W-1:0];
        it_opa = {opa_q[W-2:0], 1'b0};
      end
      it_res = (mop_q == OP_DIV) ? it_opa : it_acc;
    end
`endif
  end

  // next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    mop_d    = mop_q;
    mrd_d    = mrd_q;
    result_d = result;
    rd_out_d = rd_out;
    br_d     = br_taken;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_multi) begin
          state_d = S_ITER;
          cnt_d   = '0;
          acc_d   = '0;
          opa_d   = a;
          opb_d   = b;
          mop_d   = op;
          mrd_d   = rd_in;
        end else if (start) begin
          done_d   = 1'b1;
          result_d = sc_res;
          rd_out_d = rd_in;
          err_d    = sc_ill | ~rd_ok(rd_in);
          br_d     = (op == OP_BEQ) & comp_sig;
          wr_en_d  = ~err_d & (op != OP_BEQ);
        end
      end
      S_ITER: begin
        acc_d = it_acc;
        opa_d = it_opa;
        opb_d = it_opb;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          state_d  = S_FIN;
          done_d   = 1'b1;
          result_d = it_res;
          rd_out_d = mrd_q;
          err_d    = ~rd_ok(mrd_q);
          br_d     = 1'b0;
          wr_en_d  = ~err_d;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers; reset aborts any iteration in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      mop_q    <= '0;
      mrd_q    <= '0;
      result   <= '0;
      rd_out   <= '0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      err      <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      mop_q    <= mop_d;
      mrd_q    <= mrd_d;
      result   <= result_d;
      rd_out   <= rd_out_d;
      done     <= done_d;
      wr_en    <= wr_en_d;
      err      <= err_d;
      br_taken <= br_d;
    end
  end

endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed bench for exec_unit_mc with a scoreboard queue.
// Expected results come from a reference model; timing checked per completion.
module tb_exec_unit_mc;

  localparam int W    = 32;
  localparam int RW   = 5;
  localparam int ITER = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          comp_sig = 1'b0;
  logic [RW-1:0] rd_in = '0;
  logic          busy, done, wr_en, br_taken, err;
  logic [W-1:0]  result;
  logic [RW-1:0] rd_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    string       tag;
    int          cyc;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    logic        err;
    logic        br;
  } exp_t;

  exp_t sb[$];

  exec_unit_mc #(.W(W), .RW(RW), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .comp_sig(comp_sig), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .wr_en(wr_en),
    .br_taken(br_taken), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void model(
    input  logic [3:0]  o,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cs,
    input  logic [4:0]  r,
    output logic [31:0] res,
    output logic        e,
    output logic        br,
    output logic        wr,
    output int          lat
  );
    logic ill;
    ill = 1'b0;
    res = '0;
    lat = 1;
    case (o)
      4'd0: res = x + y;
      4'd1: res = x - y;
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: res = x ^ y;
      4'd5: res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: res = x << y[4:0];
      4'd7: res = x >> y[4:0];
      4'd8: begin res = x * y; lat = ITER + 1; end
      4'd9: res = '0;
`ifdef EXEC_DIV_EN
      4'd10: begin res = (y == 0) ? 32'hFFFF_FFFF : x / y; lat = ITER + 1; end
      4'd11: begin res = (y == 0) ? x : x % y; lat = ITER + 1; end
`endif
      default: ill = 1'b1;
    endcase
    e  = ill | ((r >= 5'd11) && (r <= 5'd24));
    br = (o == 4'd9) & cs;
    wr = !e && (o != 4'd9);
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic cs,
                       input logic [4:0] r, input string tag,
                       output int acc_e);
    exp_t        ex;
    logic [31:0] mres;
    logic        merr, mbr, mwr;
    int          lat;
    @(negedge clk);
    start    = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    comp_sig = cs;
    rd_in    = r;
    acc_e    = cyc + 1;
    model(o, x, y, cs, r, mres, merr, mbr, mwr, lat);
    ex.tag = tag;
    ex.cyc = acc_e + lat - 1;
    ex.res = mres;
    ex.rd  = r;
    ex.wr  = mwr;
    ex.err = merr;
    ex.br  = mbr;
    sb.push_back(ex);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    start = 1'b0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 64'(sb.size()) + 64'(busy), 0);
  endtask

  // completion monitor: pops the scoreboard on every done pulse
  always @(posedge clk) begin
    exp_t got;
    #1;
    if (rst && done) begin
      chk("unexpected_done", {63'b0, sb.size() == 0}, 0);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk({got.tag, "_cyc"}, 64'(cyc), 64'(got.cyc));
        chk({got.tag, "_res"}, result, got.res);
        chk({got.tag, "_rd"}, rd_out, got.rd);
        chk({got.tag, "_wr"}, wr_en, got.wr);
        chk({got.tag, "_err"}, err, got.err);
        chk({got.tag, "_br"}, br_taken, got.br);
      end
    end
    if (rst && (wr_en || err)) chk("strobe_without_done", done, 1);
  end

  initial begin
    int          e0;
    logic [31:0] exp_mul;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_rd_out", rd_out, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_err", err, 0);
    chk("rst_br", br_taken, 0);
    @(negedge clk);
    rst = 1'b1;

    issue(4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 5'd3, "add_wrap", e0);
    drain("add_wrap");

    issue(4'd8, 32'h1234, 32'h5678, 1'b0, 5'd4, "mul_abort", e0);
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e0 + 10);
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_busy_after", busy, 0);
    chk("abort_result_after", result, 0);

    issue(4'd5, 32'h8000_0000, 32'd1, 1'b0, 5'd25, "slt_neg", e0);
    issue(4'd7, 32'h8000_0000, 32'd31, 1'b0, 5'd26, "srl_31", e0);
    issue(4'd5, 32'd3, 32'd9, 1'b0, 5'd27, "slt_pos", e0);
    issue(4'd1, 32'd0, 32'd1, 1'b0, 5'd1, "sub_wrap", e0);
    issue(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 5'd2, "and", e0);
    issue(4'd3, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 5'd5, "or", e0);
    issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 5'd6, "xor", e0);
    issue(4'd6, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 5'd10, "sll_31", e0);
    drain("b2b");

    issue(4'd8, 32'h0001_0003, 32'h0000_0005, 1'b0, 5'd7, "mul", e0);
    exp_mul = 32'h0001_0003 * 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    chk("mul_busy_first", busy, 1);
    wait_cyc(e0 + 4);
    start = 1'b1;
    op    = 4'd0;
    a     = 32'd1;
    b     = 32'd1;
    rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(e0 + ITER);
    chk("mul_busy_done", busy, 1);
    wait_cyc(e0 + ITER + 1);
    chk("mul_busy_clear", busy, 0);
    repeat (3) @(negedge clk);
    chk("mul_result_held", result, exp_mul);
    drain("mul");

    issue(4'd8, 32'h0003_0003, 32'h0000_0005, 1'b0, 5'd8, "mul_f", e0);
    drain("mul_f");

    issue(4'd9, 32'd5, 32'd5, 1'b1, 5'd0, "beq_t", e0);
    issue(4'd9, 32'd5, 32'd6, 1'b0, 5'd31, "beq_nt", e0);
    issue(4'd0, 32'd7, 32'd8, 1'b0, 5'd15, "add_bad_rd", e0);
    issue(4'd13, 32'd7, 32'd8, 1'b0, 5'd4, "ill_13", e0);
    issue(4'd15, 32'd1, 32'd1, 1'b0, 5'd30, "ill_15", e0);
    drain("beq_err");

    issue(4'd10, 32'd100, 32'd7, 1'b0, 5'd3, "div", e0);
    drain("div");
    issue(4'd11, 32'd100, 32'd7, 1'b0, 5'd3, "rem", e0);
    drain("rem");
    issue(4'd10, 32'd100, 32'd0, 1'b0, 5'd4, "div_z", e0);
    drain("div_z");
    issue(4'd11, 32'd100, 32'd0, 1'b0, 5'd4, "rem_z", e0);
    drain("rem_z");

    issue(4'd8, 32'd9, 32'd9, 1'b0, 5'd20, "mul_bad_rd", e0);
    drain("mul_bad_rd");

    for (int i = 0; i < 3; i++) begin
      issue(4'd8, $urandom, $urandom, 1'b0, 5'(i + 1), "mul_rand", e0);
      drain("mul_rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
